// File: rtl/unpacked_array_serializer_if.sv
// Handshake and serial-output bundle for unpacked_array_serializer.
// master: drives valid/d, observes ready/q/q_valid/last; slave: the block.
interface unpacked_array_serializer_if #(
    parameter int M = 8,
    parameter int C = 2
);
    logic         valid;
    logic         ready;
    logic [M-1:0] d [0:C-1];
    logic [C-1:0] q;
    logic         q_valid;
    logic         last;

    modport master (
        output valid, d,
        input  ready, q, q_valid, last
    );

    modport slave (
        input  valid, d,
        output ready, q, q_valid, last
    );
endinterface

// File: rtl/unpacked_array_serializer.sv
// Multi-channel parallel-in/serial-out: loads C words of M bits, shifts all
// channels out in lockstep. Ports: clock, reset, bus (slave), word_count.
module unpacked_array_serializer #(
    parameter int M         = 8,
    parameter int C         = 2,
    parameter int MSB_FIRST = 0,
    parameter int CW        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    unpacked_array_serializer_if.slave bus,
    output logic [CW-1:0]         word_count
);
    localparam int CNTW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(M - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            p_q [0:C-1][0:M-1];
    logic            p_d [0:C-1][0:M-1];
    logic [C-1:0]    q_q, q_d;
    logic            qv_q, qv_d;
    logic            last_q, last_d;
    logic [CW-1:0]   wc_q, wc_d;

    logic            at_end;
    logic            accept;
    logic [CNTW-1:0] sel;

    // The final bit of a word is on its way out; a new word may load now.
    assign at_end    = (state_q == S_SHIFT) && (cnt_q == CNT_MAX);
    assign bus.ready = !reset && ((state_q == S_IDLE) || at_end);
    assign accept    = bus.valid && bus.ready;
    assign sel       = (MSB_FIRST != 0) ? (CNT_MAX - cnt_q) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = '0;
        qv_d    = 1'b0;
        last_d  = 1'b0;
        wc_d    = wc_q;

        if (state_q == S_SHIFT) begin
            for (int c = 0; c < C; c++) begin
                q_d[c] = p_q[c][sel];
            end
            qv_d   = 1'b1;
            last_d = at_end;
            cnt_d  = at_end ? '0 : cnt_q + CNTW'(1);
            if (at_end && !accept) begin
                state_d = S_IDLE;
            end
        end

        // Old word's last bit uses p_q above; the new word lands in p_d.
        if (accept) begin
            for (int c = 0; c < C; c++) begin
                for (int i = 0; i < M; i++) begin
                    p_d[c][i] = bus.d[c][i];
                end
            end
            state_d = S_SHIFT;
            cnt_d   = '0;
            wc_d    = wc_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            last_q  <= 1'b0;
            wc_q    <= '0;
            for (int c = 0; c < C; c++) begin
                for (int i = 0; i < M; i++) begin
                    p_q[c][i] <= 1'b0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            last_q  <= last_d;
            wc_q    <= wc_d;
            for (int c = 0; c < C; c++) begin
                for (int i = 0; i < M; i++) begin
                    p_q[c][i] <= p_d[c][i];
                end
            end
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = qv_q;
    assign bus.last    = last_q;
    assign word_count  = wc_q;
endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Scoreboard bench for unpacked_array_serializer: three instances
// (LSB-first, MSB-first, M=1/C=4/CW=2) checked by one negedge monitor.
module tb_unpacked_array_serializer;
    typedef struct packed {
        logic [3:0] q;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;
    always #5 clk = ~clk;

    unpacked_array_serializer_if #(.M(8), .C(2)) b0 ();
    unpacked_array_serializer_if #(.M(8), .C(2)) b1 ();
    unpacked_array_serializer_if #(.M(1), .C(4)) b2 ();

    logic [15:0] wc0, wc1;
    logic [1:0]  wc2;

    unpacked_array_serializer #(.M(8), .C(2), .MSB_FIRST(0), .CW(16)) u0 (
        .clock(clk), .reset(rst), .bus(b0), .word_count(wc0));
    unpacked_array_serializer #(.M(8), .C(2), .MSB_FIRST(1), .CW(16)) u1 (
        .clock(clk), .reset(rst), .bus(b1), .word_count(wc1));
    unpacked_array_serializer #(.M(1), .C(4), .MSB_FIRST(0), .CW(2)) u2 (
        .clock(clk), .reset(rst), .bus(b2), .word_count(wc2));

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    int checks = 0;
    int failures = 0;
    int run [3];
    int maxr [3];
    int lastc [3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int id, input logic qv,
                             input logic [3:0] qa, input logic la);
        exp_t e;
        int n;
        checks++;
        if (qv !== 1'b1) begin
            run[id] = 0;
            if (qv !== 1'b0 || qa !== 4'h0 || la !== 1'b0) begin
                failures++;
                $display("FAIL idle_out dut%0d qv=%b q=%h last=%b want 0/0/0",
                         id, qv, qa, la);
            end
            return;
        end
        run[id]++;
        if (run[id] > maxr[id]) maxr[id] = run[id];
        if (la === 1'b1) lastc[id]++;
        n = (id == 0) ? sb0.size() : (id == 1) ? sb1.size() : sb2.size();
        if (n == 0) begin
            failures++;
            $display("FAIL unexpected_bit dut%0d q=%h last=%b want no valid",
                     id, qa, la);
            return;
        end
        case (id)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
        if (qa !== e.q || la !== e.last) begin
            failures++;
            $display("FAIL serial_bit dut%0d q=%h last=%b want q=%h last=%b",
                     id, qa, la, e.q, e.last);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_out(0, b0.q_valid, {2'b00, b0.q}, b0.last);
            check_out(1, b1.q_valid, {2'b00, b1.q}, b1.last);
            check_out(2, b2.q_valid, b2.q, b2.last);
        end
    end

    // Drive a word into dut0/dut1, wait for ready, push expected bits.
    task automatic send8(input int id, input logic [7:0] w0,
                         input logic [7:0] w1);
        logic rdy;
        int t;
        int idx;
        exp_t e;
        if (id == 0) begin
            b0.d[0] = w0; b0.d[1] = w1; b0.valid = 1'b1;
        end else begin
            b1.d[0] = w0; b1.d[1] = w1; b1.valid = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            rdy = (id == 0) ? b0.ready : b1.ready;
            t++;
        end while (rdy !== 1'b1 && t < 60);
        if (rdy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut%0d ready=%b want 1", id, rdy);
            return;
        end
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            idx = (id == 1) ? 7 - k : k;
            e.q = {2'b00, w1[idx], w0[idx]};
            e.last = (k == 7);
            if (id == 0) sb0.push_back(e);
            else         sb1.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb0.size() + sb1.size() + sb2.size()) != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb0.size() + sb1.size() + sb2.size(), 0);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            run[i] = 0; maxr[i] = 0; lastc[i] = 0;
        end
    endtask

    logic [3:0] vecs [5];
    logic [1:0] wexp [5];
    int last_snap;

    initial begin
        exp_t e;
        vecs = '{4'b1011, 4'b0100, 4'b1111, 4'b0001, 4'b1010};
        wexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        clear_stats();
        rst = 1'b1;
        b0.valid = 1'b0; b1.valid = 1'b0; b2.valid = 1'b0;
        b0.d[0] = '0; b0.d[1] = '0; b1.d[0] = '0; b1.d[1] = '0;
        for (int c = 0; c < 4; c++) b2.d[c] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_qvalid", {b0.q_valid, b1.q_valid, b2.q_valid}, 0);
        chk("rst_q", {b0.q, b1.q, b2.q}, 0);
        chk("rst_last", {b0.last, b1.last, b2.last}, 0);
        chk("rst_wc", {wc0, wc1, 2'b00, wc2}, 0);
        chk("rst_ready", {b0.ready, b1.ready, b2.ready}, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", {b0.ready, b1.ready, b2.ready}, 3'b111);

        // LSB-first single word
        send8(0, 8'hA5, 8'h3C);
        b0.valid = 1'b0;
        drain();
        chk("t1_wc", wc0, 1);
        chk("t1_run", maxr[0], 8);
        chk("t1_lasts", lastc[0], 1);

        // MSB-first
        send8(1, 8'hA5, 8'h3C);
        b1.valid = 1'b0;
        drain();
        send8(1, 8'h01, 8'h00);
        b1.valid = 1'b0;
        drain();
        chk("t2_wc", wc1, 2);
        chk("t2_lasts", lastc[1], 2);

        // back-to-back words
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        send8(0, 8'h01, 8'h0F);
        send8(0, 8'h80, 8'hF0);
        send8(0, 8'hFF, 8'h00);
        b0.valid = 1'b0;
        drain();
        chk("t3_run", maxr[0], 24);
        chk("t3_lasts", lastc[0], 3);
        chk("t3_wc", wc0, 3);

        // reset while bit 4 is on the output
        send8(0, 8'hC3, 8'h5A);
        b0.valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        last_snap = lastc[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb0.delete();
        chk("t4_qvalid", b0.q_valid, 0);
        chk("t4_q", b0.q, 0);
        chk("t4_last", b0.last, 0);
        chk("t4_wc", wc0, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_last", lastc[0], last_snap);
        send8(0, 8'h96, 8'h69);
        b0.valid = 1'b0;
        drain();
        chk("t4_reload_wc", wc0, 1);

        // M=1, four channels, CW=2 wrap
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 4; c++) b2.d[c] = vecs[i][c];
            b2.valid = 1'b1;
            @(negedge clk);
            chk("t5_ready", b2.ready, 1);
            @(posedge clk);
            e.q = vecs[i];
            e.last = 1'b1;
            sb2.push_back(e);
            #1;
            chk("t5_wc", wc2, wexp[i]);
        end
        b2.valid = 1'b0;
        drain();
        chk("t5_run", maxr[2], 5);
        chk("t5_lasts", lastc[2], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
